// File: rtl/key_conditioner_if.sv
// key_conditioner_if
//   Bundle of the raw key inputs and the conditioned key outputs of
//   key_conditioner.
//   master : drives key_raw and observes the conditioned outputs.
//   slave  : the conditioner itself. It reads key_raw and drives the rest.
// Signals (all WIDTH bits, one bit per key)
//   key_raw       raw asynchronous key levels, active-high
//   key_clean     debounced level
//   key_rise      one-cycle pulse on a debounced 0->1
//   key_fall      one-cycle pulse on a debounced 1->0
//   key_toggle    toggle latch, flips on each key_rise
//   key_out       per-key select between key_toggle and key_clean
//   key_settling  high while that key's debounce counter is non-zero
interface key_conditioner_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] key_raw;
  logic [WIDTH-1:0] key_clean;
  logic [WIDTH-1:0] key_rise;
  logic [WIDTH-1:0] key_fall;
  logic [WIDTH-1:0] key_toggle;
  logic [WIDTH-1:0] key_out;
  logic [WIDTH-1:0] key_settling;

  modport master (
    output key_raw,
    input  key_clean, key_rise, key_fall, key_toggle, key_out, key_settling
  );

  modport slave (
    input  key_raw,
    output key_clean, key_rise, key_fall, key_toggle, key_out, key_settling
  );
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner
//   Input stage for board keys. Each key is synchronised through two flops
//   and debounced independently. The block then produces a clean level,
//   one-cycle rise/fall pulses and a toggle latch for every key.
//   key_out selects the toggle latch for bits set in TOGGLE_MASK, so those
//   keys behave as latched switches. Every other bit of key_out is the
//   clean level.
// Ports
//   clock   in   system clock, rising edge
//   reset   in   synchronous, active-low
//   kif     key_conditioner_if.slave (key_raw in; all conditioned outputs out)
module key_conditioner #(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 270000,
  parameter logic [WIDTH-1:0] TOGGLE_MASK     = WIDTH'(8'h08)
) (
  input  logic              clock,
  input  logic              reset,
  key_conditioner_if.slave  kif
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // Terminal count. A difference that is still present when the counter
  // sits here is accepted on this edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] clean_r;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic [WIDTH-1:0] toggle_r;
  logic [CNT_W-1:0] cnt_r [WIDTH];
  logic [WIDTH-1:0] settling_s;

  // Synchroniser, per-key debounce counters, clean level, edge pulses, toggle latches
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_r  <= '0;
      sync2_r  <= '0;
      clean_r  <= '0;
      rise_r   <= '0;
      fall_r   <= '0;
      toggle_r <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= kif.key_raw;
      sync2_r <= sync1_r;
      for (int i = 0; i < WIDTH; i++) begin
        // Pulses last one cycle unless this edge accepts a new level.
        rise_r[i] <= 1'b0;
        fall_r[i] <= 1'b0;
        if (sync2_r[i] == clean_r[i]) begin
          // Agreement, or a bounce back before the terminal count, restarts the count.
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          clean_r[i] <= sync2_r[i];
          cnt_r[i]   <= '0;
          rise_r[i]  <= sync2_r[i];
          fall_r[i]  <= ~sync2_r[i];
          if (sync2_r[i]) begin
            toggle_r[i] <= ~toggle_r[i];
          end else begin
            toggle_r[i] <= toggle_r[i];
          end
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // A key is settling while its counter holds a pending change
  always_comb begin
    settling_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      settling_s[i] = (cnt_r[i] != '0);
    end
  end

  assign kif.key_clean    = clean_r;
  assign kif.key_rise     = rise_r;
  assign kif.key_fall     = fall_r;
  assign kif.key_toggle   = toggle_r;
  assign kif.key_out      = (toggle_r & TOGGLE_MASK) | (clean_r & ~TOGGLE_MASK);
  assign kif.key_settling = settling_s;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner
//   Directed bench for key_conditioner with DEBOUNCE_CYCLES=4 and TOGGLE_MASK=8'h08.
//   The stimulus process queues the expected event (edge number plus the
//   outputs) whenever it drives a key change. The monitor pops an entry and
//   compares it each time the DUT emits a rise/fall pulse.
module tb_key_conditioner;

  localparam int         WIDTH = 8;
  localparam int         DEB   = 4;
  localparam logic [7:0] MASK  = 8'h08;

  typedef struct {
    int         cyc;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] clean;
    logic [7:0] toggle;
    logic [7:0] out;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  key_conditioner_if #(.WIDTH(WIDTH)) kif ();

  key_conditioner #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .TOGGLE_MASK(MASK)
  ) dut (
    .clock(clock),
    .reset(reset),
    .kif(kif.slave)
  );

  always #5 clock = ~clock;

  // Rising-edge counter used to time expected events
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // A change driven while cyc==c is accepted on edge c+DEB+2.
  task automatic expect_ev(input logic [7:0] r, input logic [7:0] f, input logic [7:0] c,
                           input logic [7:0] t, input logic [7:0] o);
    exp_t e;
    e.cyc    = cyc + DEB + 2;
    e.rise   = r;
    e.fall   = f;
    e.clean  = c;
    e.toggle = t;
    e.out    = o;
    sb.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: compares every emitted pulse against the scoreboard head
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_checks++;
      $display("FAIL missed_event: no pulse by cycle %0d, expected at cycle %0d", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if ((kif.key_rise | kif.key_fall) != 8'h00) begin
      chk("rise_fall_exclusive", kif.key_rise & kif.key_fall, 8'h00);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: rise %h fall %h at cycle %0d, expected none",
                 kif.key_rise, kif.key_fall, cyc);
      end else begin
        e = sb.pop_front();
        chk_int("event_cycle", cyc, e.cyc);
        chk("ev_rise", kif.key_rise, e.rise);
        chk("ev_fall", kif.key_fall, e.fall);
        chk("ev_clean", kif.key_clean, e.clean);
        chk("ev_toggle", kif.key_toggle, e.toggle);
        chk("ev_out", kif.key_out, e.out);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d cycles, expected fewer", cyc);
    $fatal(1);
  end

  initial begin
    // Reset held with all keys pressed
    reset = 1'b0;
    kif.key_raw = 8'hFF;
    wait_neg(3);
    chk("rst_clean", kif.key_clean, 8'h00);
    chk("rst_rise", kif.key_rise, 8'h00);
    chk("rst_fall", kif.key_fall, 8'h00);
    chk("rst_toggle", kif.key_toggle, 8'h00);
    chk("rst_out", kif.key_out, 8'h00);
    chk("rst_settling", kif.key_settling, 8'h00);
    reset = 1'b1;
    expect_ev(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF);
    wait_neg(10);
    kif.key_raw = 8'h00;
    expect_ev(8'h00, 8'hFF, 8'h00, 8'hFF, 8'h08);
    wait_neg(10);

    // Clear toggle latches again
    reset = 1'b0;
    wait_neg(1);
    chk("clr_toggle", kif.key_toggle, 8'h00);
    chk("clr_out", kif.key_out, 8'h00);
    reset = 1'b1;
    wait_neg(2);

    // Single key press/release with settling visible mid-count
    kif.key_raw = 8'h01;
    expect_ev(8'h01, 8'h00, 8'h01, 8'h01, 8'h01);
    wait_neg(3);
    chk("settling_k0", kif.key_settling, 8'h01);
    wait_neg(7);
    kif.key_raw = 8'h00;
    expect_ev(8'h00, 8'h01, 8'h00, 8'h01, 8'h00);
    wait_neg(10);

    // Bounce on key 1, then a steady press
    kif.key_raw = 8'h02; wait_neg(1);
    kif.key_raw = 8'h00; wait_neg(1);
    kif.key_raw = 8'h02; wait_neg(1);
    kif.key_raw = 8'h00; wait_neg(1);
    kif.key_raw = 8'h02;
    expect_ev(8'h02, 8'h00, 8'h02, 8'h03, 8'h02);
    wait_neg(12);
    kif.key_raw = 8'h00;
    expect_ev(8'h00, 8'h02, 8'h00, 8'h03, 8'h00);
    wait_neg(10);

    // Key 3 as a latched switch: press, release, press, release
    kif.key_raw = 8'h08;
    expect_ev(8'h08, 8'h00, 8'h08, 8'h0B, 8'h08);
    wait_neg(10);
    kif.key_raw = 8'h00;
    expect_ev(8'h00, 8'h08, 8'h00, 8'h0B, 8'h08);
    wait_neg(10);
    chk("latched_out3", {7'b0000000, kif.key_out[3]}, 8'h01);
    chk("latched_clean3", {7'b0000000, kif.key_clean[3]}, 8'h00);
    kif.key_raw = 8'h08;
    expect_ev(8'h08, 8'h00, 8'h08, 8'h03, 8'h00);
    wait_neg(10);
    kif.key_raw = 8'h00;
    expect_ev(8'h00, 8'h08, 8'h00, 8'h03, 8'h00);
    wait_neg(10);

    // Simultaneous keys 0 and 2
    kif.key_raw = 8'h05;
    expect_ev(8'h05, 8'h00, 8'h05, 8'h06, 8'h05);
    wait_neg(10);
    kif.key_raw = 8'h00;
    expect_ev(8'h00, 8'h05, 8'h00, 8'h06, 8'h00);
    wait_neg(10);

    // Set toggle[3], then reset in the middle of a key 2 count
    kif.key_raw = 8'h08;
    expect_ev(8'h08, 8'h00, 8'h08, 8'h0E, 8'h08);
    wait_neg(10);
    kif.key_raw = 8'h00;
    expect_ev(8'h00, 8'h08, 8'h00, 8'h0E, 8'h08);
    wait_neg(10);
    kif.key_raw = 8'h04;
    wait_neg(4);
    chk("pre_rst_settling", kif.key_settling, 8'h04);
    chk("pre_rst_toggle", kif.key_toggle, 8'h0E);
    reset = 1'b0;
    wait_neg(1);
    chk("mid_rst_settling", kif.key_settling, 8'h00);
    chk("mid_rst_toggle", kif.key_toggle, 8'h00);
    chk("mid_rst_clean", kif.key_clean, 8'h00);
    chk("mid_rst_out", kif.key_out, 8'h00);
    chk("mid_rst_rise", kif.key_rise, 8'h00);
    chk("mid_rst_fall", kif.key_fall, 8'h00);
    // Key 2 held through reset appears as a fresh press
    reset = 1'b1;
    expect_ev(8'h04, 8'h00, 8'h04, 8'h04, 8'h04);
    wait_neg(10);

    chk_int("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
